way_onehot_decoder: RTL

Parametrised binary-to-one-hot decoder with a registered, handshaked output stage and a built-in round-robin victim pointer. It is the next generation of the fixed 3-to-8 decoder. It drives one-hot way enables for the cache data/tag arrays and register-file write enables from a single block. Requests come from the cache controller or writeback stage. The registered one-hot result feeds array write-enable logic.

---
 rtl/way_onehot_decoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/way_onehot_decoder.sv
// Binary-to-one-hot way decoder with a registered valid/ready output stage and round-robin victim.
// Define WAY_DEC_LOCK_EN to add lock_mask_i / all_locked_o and lock-aware victim selection.
module way_onehot_decoder #(
  parameter int unsigned CODE_W = 3,
  localparam int unsigned NUM_OUT = 2 ** CODE_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               mode_i,
  input  logic [CODE_W-1:0]  code_i,
`ifdef WAY_DEC_LOCK_EN
  input  logic [NUM_OUT-1:0] lock_mask_i,
  output logic               all_locked_o,
`endif
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [NUM_OUT-1:0] onehot_o,
  output logic [CODE_W-1:0]  code_o,
  output logic [CODE_W-1:0]  ptr_o
);

  logic               out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0] onehot_q, onehot_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  ptr_q, ptr_d;
  logic               accept;
  logic [CODE_W-1:0]  victim;
  logic               victim_found;
`ifdef WAY_DEC_LOCK_EN
  logic               all_locked_q, all_locked_d;
`endif

  // Single register stage: a draining consumer frees the slot in the same cycle.
  assign req_ready_o = ~out_valid_q | out_ready_i;
  assign accept      = req_valid_i & req_ready_o;

`ifdef WAY_DEC_LOCK_EN
  // Cyclic priority search: nearest unlocked way at or above the pointer wins.
  always_comb begin
    victim       = ptr_q;
    victim_found = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (!victim_found && !lock_mask_i[ptr_q + CODE_W'(i)]) begin
        victim       = ptr_q + CODE_W'(i);
        victim_found = 1'b1;
      end
    end
  end
`else
  assign victim       = ptr_q;
  assign victim_found = 1'b1;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    onehot_d    = onehot_q;
    code_d      = code_q;
    ptr_d       = ptr_q;
`ifdef WAY_DEC_LOCK_EN
    all_locked_d = all_locked_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      if (!mode_i) begin
        code_d   = code_i;
        onehot_d = NUM_OUT'(1) << code_i;
`ifdef WAY_DEC_LOCK_EN
        all_locked_d = 1'b0;
`endif
      end else if (victim_found) begin
        code_d   = victim;
        onehot_d = NUM_OUT'(1) << victim;
        ptr_d    = victim + CODE_W'(1);
`ifdef WAY_DEC_LOCK_EN
        all_locked_d = 1'b0;
`endif
      end else begin
        // Every way locked: report the pointer, no enable, pointer holds.
        code_d   = ptr_q;
        onehot_d = '0;
`ifdef WAY_DEC_LOCK_EN
        all_locked_d = 1'b1;
`endif
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      onehot_q    <= '0;
      code_q      <= '0;
      ptr_q       <= '0;
`ifdef WAY_DEC_LOCK_EN
      all_locked_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      onehot_q    <= onehot_d;
      code_q      <= code_d;
      ptr_q       <= ptr_d;
`ifdef WAY_DEC_LOCK_EN
      all_locked_q <= all_locked_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign onehot_o    = onehot_q;
  assign code_o      = code_q;
  assign ptr_o       = ptr_q;
`ifdef WAY_DEC_LOCK_EN
  assign all_locked_o = all_locked_q;
`endif

endmodule
